serial_theta_key_engine: RTL and testbench

Multi-cycle, parametrised successor to the combinational theta/key-add layer of the SWAN round. Accepts one half-state word and one round-key half per transaction. Processes the four columns serially, one column per clock, through a single shared rotate/XOR datapath. Supports forward (encrypt) and inverse (decrypt) modes, with valid/ready handshakes on both sides, and sits between the round-state register and the next round stage.

---
 rtl/serial_theta_key_engine.sv | 121 ++++++++++++
 tb/tb_serial_theta_key_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_theta_key_engine.sv
// Serial theta/key-add layer for the SWAN round. It processes one column per clock through a
// single shared rotator and supports forward (mode=0) and inverse (mode=1) operation.
module serial_theta_key_engine #(
    parameter int BLOCK_SIZE = 128,
    parameter int PA = 1,
    parameter int PB = 3,
    parameter int PC = 13,
    localparam int SIDE_SIZE = BLOCK_SIZE / 2,
    localparam int COLUMN_SIZE = SIDE_SIZE / 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [SIDE_SIZE-1:0] x,
    input  logic [SIDE_SIZE-1:0] rk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIDE_SIZE-1:0] y
);
    // state | meaning
    // IDLE  | waiting for a transaction, in_ready=1
    // BUSY  | one column per cycle, cnt 0..3
    // DONE  | result presented, held until out_ready
    localparam int RW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [SIDE_SIZE-1:0]   x_reg, rk_reg, y_reg;
    logic                   mode_reg;
    logic [1:0]             cnt;
    logic                   out_valid_reg;
    logic                   accept;
    logic [1:0]             col_sel;
    int                     col_base;
    logic [COLUMN_SIZE-1:0] col_x, col_rk, rot_in, rot_out, col_res;
    logic [RW-1:0]          rot_amt, amt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (cnt == 2'd3) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? S_BUSY : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Column 0 sits in the most significant bits, so column cnt lives at slot 3-cnt.
    always_comb begin
        col_sel  = 2'd3 - cnt;
        col_base = int'(col_sel) * COLUMN_SIZE;
        col_x    = x_reg[col_base +: COLUMN_SIZE];
        col_rk   = rk_reg[col_base +: COLUMN_SIZE];
        case (cnt)
            2'd0:    rot_amt = RW'(PC);
            2'd1:    rot_amt = RW'(PB);
            2'd2:    rot_amt = RW'(PA);
            default: rot_amt = '0;
        endcase
        // Inverse rotates left, which is a right rotate by the complement amount.
        if (mode_reg && rot_amt != '0)
            amt = RW'(COLUMN_SIZE - int'(rot_amt));
        else
            amt = rot_amt;
        rot_in  = mode_reg ? (col_x ^ col_rk) : col_x;
        rot_out = COLUMN_SIZE'({rot_in, rot_in} >> amt);
        col_res = mode_reg ? rot_out : (rot_out ^ col_rk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg         <= '0;
            rk_reg        <= '0;
            mode_reg      <= 1'b0;
            cnt           <= 2'd0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                x_reg    <= x;
                rk_reg   <= rk;
                mode_reg <= mode;
                cnt      <= 2'd0;
            end else if (state == S_BUSY) begin
                y_reg[col_base +: COLUMN_SIZE] <= col_res;
                cnt                            <= cnt + 2'd1;
            end
            if (state == S_BUSY && cnt == 2'd3)
                out_valid_reg <= 1'b1;
            else if (state == S_DONE && out_ready)
                out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign y         = y_reg;

endmodule

// File: tb/tb_serial_theta_key_engine.sv
// Directed and random checks of serial_theta_key_engine at BLOCK_SIZE 128 and 256,
// using a queue of expected results and an independent bitwise reference model.
module tb_serial_theta_key_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid = 0, a_in_ready, a_mode = 0, a_out_valid, a_out_ready = 0;
    logic [63:0] a_x = '0, a_rk = '0, a_y;
    logic         b_in_valid = 0, b_in_ready, b_mode = 0, b_out_valid, b_out_ready = 0;
    logic [127:0] b_x = '0, b_rk = '0, b_y;

    serial_theta_key_engine #(.BLOCK_SIZE(128)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
        .x(a_x), .rk(a_rk), .out_valid(a_out_valid), .out_ready(a_out_ready), .y(a_y));

    serial_theta_key_engine #(.BLOCK_SIZE(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
        .x(b_x), .rk(b_rk), .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y));

    int vectors = 0;
    int errs = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_model(input int side, input logic m,
                                               input logic [127:0] xx, input logic [127:0] rr);
        logic [127:0] r;
        int c, rot, src;
        r = '0;
        c = side / 4;
        for (int k = 0; k < 4; k++) begin
            rot = (k == 0) ? 13 : (k == 1) ? 3 : (k == 2) ? 1 : 0;
            for (int j = 0; j < c; j++) begin
                if (!m) begin
                    src = (j - rot + c) % c;
                    r[side-1-(k*c+j)] = xx[side-1-(k*c+src)] ^ rr[side-1-(k*c+j)];
                end else begin
                    src = (j + rot) % c;
                    r[side-1-(k*c+j)] = xx[side-1-(k*c+src)] ^ rr[side-1-(k*c+src)];
                end
            end
        end
        return r;
    endfunction

    task automatic drive(input bit w, input logic v, input logic m,
                         input logic [127:0] xx, input logic [127:0] rr);
        if (w) begin
            b_in_valid = v; b_mode = m; b_x = xx; b_rk = rr;
        end else begin
            a_in_valid = v; a_mode = m; a_x = xx[63:0]; a_rk = rr[63:0];
        end
    endtask

    task automatic set_or(input bit w, input logic v);
        if (w) b_out_ready = v; else a_out_ready = v;
    endtask

    function automatic logic [127:0] get_y(input bit w);
        return w ? b_y : {64'd0, a_y};
    endfunction
    function automatic logic get_ov(input bit w);
        return w ? b_out_valid : a_out_valid;
    endfunction
    function automatic logic get_ir(input bit w);
        return w ? b_in_ready : a_in_ready;
    endfunction

    // Called at the first negedge after the handshake edge.
    task automatic wait_result(input bit w, output logic [127:0] yo);
        int n;
        logic [127:0] e;
        n = 0;
        while (!get_ov(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 128'(n), 128'(4));
        yo = get_y(w);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("y", yo, e);
        set_or(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_or(w, 1'b0);
    endtask

    task automatic run_txn(input bit w, input logic m, input logic [127:0] xx,
                           input logic [127:0] rr, input logic [127:0] exp,
                           output logic [127:0] yo);
        exp_q.push_back(exp);
        drive(w, 1'b1, m, xx, rr);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, m, xx, rr);
        wait_result(w, yo);
    endtask

    function automatic logic [127:0] rnd(input bit w);
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return w ? v : {64'd0, v[63:0]};
    endfunction

    logic [127:0] yo, y_hold, xr, rr, yf;

    initial begin
        #1;
        check("rst_in_ready_a", 128'(a_in_ready), 128'(1));
        check("rst_out_valid_a", 128'(a_out_valid), 128'(0));
        check("rst_y_a", get_y(0), '0);
        check("rst_y_b", get_y(1), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(0, 0, 128'h0001_0001_0001_0001, '0, 128'h0008_2000_8000_0001, yo);
        run_txn(0, 0, '0, 128'h1234_5678_9ABC_DEF0, 128'h1234_5678_9ABC_DEF0, yo);
        run_txn(0, 1, '0, 128'h1234_5678_9ABC_DEF0, 128'h8246_B3C2_3579_DEF0, yo);
        run_txn(0, 1, 128'h0008_2000_8000_0001, '0, 128'h0001_0001_0001_0001, yo);

        // Backpressure: hold out_ready low while inputs churn.
        exp_q.push_back(128'h0008_2000_8000_0001);
        drive(0, 1, 0, 128'h0001_0001_0001_0001, '0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, '0, '0);
        for (int n = 0; n < 4 && !a_out_valid; n++) @(negedge clk);
        y_hold = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 1'(($urandom & 1)), rnd(0), rnd(0));
            #1;
            check("bp_out_valid", 128'(a_out_valid), 128'(1));
            check("bp_y", get_y(0), y_hold);
            check("bp_in_ready", 128'(a_in_ready), 128'(0));
            @(negedge clk);
        end
        xr = rnd(0); rr = rnd(0);
        exp_q.push_back(ref_model(64, 0, xr, rr));
        drive(0, 1, 0, xr, rr);
        set_or(0, 1);
        #1;
        check("bp_accept_in_ready", 128'(a_in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        set_or(0, 0);
        drive(0, 0, 1, rnd(0), rnd(0));
        check("bp_next_not_valid", 128'(a_out_valid), 128'(0));
        wait_result(0, yo);

        // Reset two cycles after a handshake.
        exp_q.push_back(128'hDEAD);
        drive(0, 1, 0, 128'h0001_0001_0001_0001, 128'h5555);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_mid_y", get_y(0), '0);
        check("rst_mid_in_ready", 128'(a_in_ready), 128'(1));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, 1, '0, 128'h1234_5678_9ABC_DEF0, 128'h8246_B3C2_3579_DEF0, yo);

        // Random round-trip at both widths.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1000; i++) begin
                xr = rnd(w[0]);
                rr = rnd(w[0]);
                run_txn(w[0], 0, xr, rr, ref_model(w[0] ? 128 : 64, 0, xr, rr), yf);
                run_txn(w[0], 1, yf, rr, xr, yo);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
